// File: rtl/router_pkg.sv
// Shared router types: flit format, arbiter state encoding and the bit positions in the arbiter error vector.
package router_pkg;

  localparam int FLIT_SIZE = 32;

  typedef enum logic [1:0] {
    HEAD_FLIT = 2'd0,
    BODY_FLIT = 2'd1,
    TAIL_FLIT = 2'd2,
    NONE_FLIT = 2'd3
  } FLIT_TYPE_t;

  typedef struct packed {
    logic                 valid;
    FLIT_TYPE_t           flit_type;
    logic [FLIT_SIZE-1:0] data;
  } FLIT_t;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    GRANT = 2'd1,
    FWD   = 2'd2
  } ARB_STATE_t;

  localparam int ARB_ERR_FRAME   = 0;
  localparam int ARB_ERR_STRAY   = 1;
  localparam int ARB_ERR_TIMEOUT = 2;

endpackage

// File: rtl/tg_injection_arbiter_if.sv
// Generator-array / router-injection bus that is shared through tg_injection_arbiter.
interface tg_injection_arbiter_if #(
  parameter int NUM_REQ = 4
) ();

  logic [NUM_REQ-1:0]                  i_req;
  logic [NUM_REQ-1:0]                  o_grant;
  router_pkg::FLIT_t [NUM_REQ-1:0]     i_flit;
  logic                                i_out_rdy;
  router_pkg::FLIT_t                   o_flit;

  modport slave (
    input  i_req,
    input  i_flit,
    input  i_out_rdy,
    output o_grant,
    output o_flit
  );

  modport master (
    output i_req,
    output i_flit,
    output i_out_rdy,
    input  o_grant,
    input  o_flit
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, searching cyclically upward.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 valid,
  output logic [$clog2(N)-1:0] idx
);

  localparam int W = $clog2(N);

  logic [N-1:0]   mask_d;
  logic [2*N-1:0] dbl_d;
  logic [W:0]     pos_d;

  // Lower half holds requests at/above ptr, upper half the full set for the wrap-around.
  assign mask_d = req & ({N{1'b1}} << ptr);
  assign dbl_d  = {req, mask_d};

  always_comb begin
    pos_d = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (dbl_d[i]) pos_d = (W+1)'(i);
    end
  end

  assign valid = |req;
  assign idx   = (pos_d >= (W+1)'(N)) ? W'(pos_d - (W+1)'(N)) : W'(pos_d);

endmodule

// File: rtl/tg_injection_arbiter.sv
// Packet-atomic round-robin arbiter sharing one router injection port among NUM_REQ traffic generators.
// Optional idle watchdog while locked: define TG_INJ_ARB_WATCHDOG_EN.
module tg_injection_arbiter import router_pkg::*; #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  tg_injection_arbiter_if.slave      bus,
  output logic                       o_busy,
  output logic [$clog2(NUM_REQ)-1:0] o_owner,
  output logic [15:0]                o_pkt_count,
  output logic [2:0]                 o_err
);

  localparam int IW = $clog2(NUM_REQ);

  ARB_STATE_t         state_q;
  logic [NUM_REQ-1:0] grant_q;
  FLIT_t              flit_q;
  logic               busy_q;
  logic [IW-1:0]      owner_q;
  logic [IW-1:0]      rr_ptr_q;
  logic [15:0]        pkt_cnt_q;
  logic [2:0]         err_q;
  logic               first_seen_q;

  logic               pick_valid_d;
  logic [IW-1:0]      pick_idx_d;
  FLIT_t              own_flit_d;
  logic [IW-1:0]      next_ptr_d;
  logic [NUM_REQ-1:0] stray_vec_d;
  logic               wd_fire_d;

  rr_pick #(.N(NUM_REQ)) u_rr_pick (
    .req   (bus.i_req),
    .ptr   (rr_ptr_q),
    .valid (pick_valid_d),
    .idx   (pick_idx_d)
  );

  assign own_flit_d = bus.i_flit[owner_q];
  assign next_ptr_d = (owner_q == IW'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;

  // During GRANT even the new owner's flits are premature, so every valid flit is stray.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stray
    assign stray_vec_d[gi] = bus.i_flit[gi].valid &&
                             ((state_q == GRANT) || (owner_q != IW'(gi)));
  end

`ifdef TG_INJ_ARB_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WW-1:0] wd_cnt_q;

  assign wd_fire_d = (state_q == FWD) && !own_flit_d.valid &&
                     (wd_cnt_q + 1'b1 == WW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_q <= '0;
    end else if ((state_q != FWD) || own_flit_d.valid || wd_fire_d) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
    end
  end
`else
  assign wd_fire_d = 1'b0;
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ARB;
      grant_q      <= '0;
      flit_q       <= '0;
      busy_q       <= 1'b0;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      pkt_cnt_q    <= '0;
      err_q        <= '0;
      first_seen_q <= 1'b0;
    end else begin
      if (|stray_vec_d) err_q[ARB_ERR_STRAY] <= 1'b1;
      case (state_q)
        ARB: begin
          flit_q <= '0;
          if (bus.i_out_rdy && pick_valid_d) begin
            grant_q <= NUM_REQ'(1) << pick_idx_d;
            owner_q <= pick_idx_d;
            busy_q  <= 1'b1;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          flit_q       <= '0;
          first_seen_q <= 1'b0;
          state_q      <= FWD;
        end
        FWD: begin
          if (own_flit_d.valid) begin
            flit_q       <= own_flit_d;
            first_seen_q <= 1'b1;
            if (!first_seen_q && (own_flit_d.flit_type != HEAD_FLIT))
              err_q[ARB_ERR_FRAME] <= 1'b1;
            if (own_flit_d.flit_type == TAIL_FLIT) begin
              grant_q   <= '0;
              rr_ptr_q  <= next_ptr_d;
              pkt_cnt_q <= pkt_cnt_q + 16'd1;
              busy_q    <= 1'b0;
              state_q   <= ARB;
            end
          end else begin
            flit_q <= '0;
            if (wd_fire_d) begin
              err_q[ARB_ERR_TIMEOUT] <= 1'b1;
              grant_q  <= '0;
              rr_ptr_q <= next_ptr_d;
              busy_q   <= 1'b0;
              state_q  <= ARB;
            end
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign bus.o_grant = grant_q;
  assign bus.o_flit  = flit_q;
  assign o_busy      = busy_q;
  assign o_owner     = owner_q;
  assign o_pkt_count = pkt_cnt_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_tg_injection_arbiter.sv
// Directed plus randomized bench for tg_injection_arbiter against a packet-level reference model.
module tb_tg_injection_arbiter;
  import router_pkg::*;

  localparam int N  = 4;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        o_busy;
  logic [1:0]  o_owner;
  logic [15:0] o_pkt_count;
  logic [2:0]  o_err;

  int checks = 0;
  int errors = 0;

  // Reference model state, expressed per packet rather than per register.
  int         ptr_m = 0;
  int         cnt_m = 0;
  logic [2:0] err_m = '0;
  bit         locked_m = 0;
  bit         first_m = 0;

  tg_injection_arbiter_if #(.NUM_REQ(N)) bus ();

  tg_injection_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .o_busy      (o_busy),
    .o_owner     (o_owner),
    .o_pkt_count (o_pkt_count),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int winner(input logic [N-1:0] mask, input int ptr);
    for (int d = 0; d < N; d++) begin
      if (mask[(ptr + d) % N]) return (ptr + d) % N;
    end
    return -1;
  endfunction

  function automatic FLIT_t mk(input FLIT_TYPE_t t, input logic [31:0] d);
    FLIT_t f;
    f = '0;
    f.valid = 1'b1;
    f.flit_type = t;
    f.data = d;
    return f;
  endfunction

  task automatic arbitrate(input logic [N-1:0] mask, input string tag, output int w);
    bus.i_flit = '0;
    bus.i_req = mask;
    bus.i_out_rdy = 1'b1;
    tick();
    w = winner(mask, ptr_m);
    locked_m = 1;
    first_m = 0;
    $display("arb %s: req=%b ptr=%0d -> grant=%b owner=%0d", tag, mask, ptr_m, bus.o_grant, o_owner);
    check({tag, "_grant"}, 64'(bus.o_grant), 64'(1) << w);
    check({tag, "_owner"}, 64'(o_owner), 64'(w));
    check({tag, "_busy"}, 64'(o_busy), 64'(1));
    tick();
    check({tag, "_grant_hold"}, 64'(bus.o_grant), 64'(1) << w);
  endtask

  task automatic send_flit(input FLIT_t f, input int w, input int sk, input string tag);
    FLIT_t ef;
    bus.i_flit = '0;
    bus.i_flit[w] = f;
    if (sk >= 0) begin
      bus.i_flit[sk] = mk(BODY_FLIT, 32'hDEAD_0000 | 32'(sk));
      err_m[ARB_ERR_STRAY] = 1'b1;
    end
    tick();
    ef = f.valid ? f : '0;
    if (f.valid) begin
      if (!first_m && f.flit_type != HEAD_FLIT) err_m[ARB_ERR_FRAME] = 1'b1;
      first_m = 1;
      if (f.flit_type == TAIL_FLIT) begin
        locked_m = 0;
        ptr_m = (w + 1) % N;
        cnt_m = (cnt_m + 1) % 65536;
      end
    end
    $display("flit %s: owner=%0d in=%h stray=%0d out=%h grant=%b err=%b cnt=%0d",
             tag, w, f, sk, bus.o_flit, bus.o_grant, o_err, o_pkt_count);
    check({tag, "_flit"}, 64'(bus.o_flit), 64'(ef));
    check({tag, "_grant"}, 64'(bus.o_grant), locked_m ? (64'(1) << w) : 64'(0));
    check({tag, "_busy"}, 64'(o_busy), 64'(locked_m));
    check({tag, "_owner"}, 64'(o_owner), 64'(w));
    check({tag, "_err"}, 64'(o_err), 64'(err_m));
    check({tag, "_cnt"}, 64'(o_pkt_count), 64'(cnt_m));
  endtask

  task automatic send_packet(input int w, input int len, input int gap_pct,
                             input int stray_pct, input bit bad_first, input string tag);
    FLIT_TYPE_t t;
    int sk;
    for (int i = 0; i < len; i++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) send_flit('0, w, -1, tag);
      if (i == len - 1)   t = TAIL_FLIT;
      else if (i == 0)    t = bad_first ? BODY_FLIT : HEAD_FLIT;
      else                t = BODY_FLIT;
      sk = -1;
      if (stray_pct > 0 && $urandom_range(0, 99) < stray_pct)
        sk = (w + $urandom_range(1, N - 1)) % N;
      send_flit(mk(t, $urandom), w, sk, tag);
    end
    bus.i_flit = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 64'(bus.o_grant), 64'(0));
    check({tag, "_flit"}, 64'(bus.o_flit), 64'(0));
    check({tag, "_busy"}, 64'(o_busy), 64'(0));
    check({tag, "_owner"}, 64'(o_owner), 64'(0));
    check({tag, "_cnt"}, 64'(o_pkt_count), 64'(0));
    check({tag, "_err"}, 64'(o_err), 64'(0));
  endtask

  initial begin
    int w;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] mask;

    bus.i_req = '0;
    bus.i_flit = '0;
    bus.i_out_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // Fairness from reset: every generator requesting, one packet each.
    for (int i = 0; i < 5; i++) begin
      arbitrate(4'b1111, "rr", w);
      check("rr_order", 64'(o_owner), 64'(exp_order[i]));
      send_packet(w, 2, 0, 0, 0, "rr");
    end

    // Single requester; afterwards the pointer sits just past it.
    bus.i_req = '0;
    tick();
    arbitrate(4'b0100, "single", w);
    send_packet(w, 4, 0, 0, 0, "single");
    arbitrate(4'b1111, "after_single", w);
    check("after_single_owner3", 64'(o_owner), 64'(3));
    send_packet(w, 2, 0, 0, 0, "after_single");

    // Backpressure at arbitration.
    bus.i_req = 4'b0001;
    bus.i_out_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_no_grant", 64'(bus.o_grant), 64'(0));
    end
    arbitrate(4'b0001, "bp", w);
    send_packet(w, 3, 0, 0, 0, "bp");

    // Long stall after HEAD.
    arbitrate(4'b0010, "stall", w);
    send_flit(mk(HEAD_FLIT, 32'h1234_5678), w, -1, "stall_head");
`ifdef TG_INJ_ARB_WATCHDOG_EN
    for (int i = 0; i < TO - 1; i++) send_flit('0, w, -1, "wd_wait");
    bus.i_flit = '0;
    tick();
    err_m[ARB_ERR_TIMEOUT] = 1'b1;
    locked_m = 0;
    ptr_m = (w + 1) % N;
    $display("wd abort: grant=%b err=%b cnt=%0d", bus.o_grant, o_err, o_pkt_count);
    check("wd_grant", 64'(bus.o_grant), 64'(0));
    check("wd_busy", 64'(o_busy), 64'(0));
    check("wd_err", 64'(o_err), 64'(err_m));
    check("wd_cnt", 64'(o_pkt_count), 64'(cnt_m));
`else
    for (int i = 0; i < 20; i++) send_flit('0, w, -1, "stall_wait");
    send_flit(mk(TAIL_FLIT, 32'h8765_4321), w, -1, "stall_tail");
`endif

    // Stray flit from generator 2 while generator 1 owns the port.
    bus.i_req = '0;
    tick();
    arbitrate(4'b0010, "stray", w);
    send_flit(mk(HEAD_FLIT, 32'hA0), w, -1, "stray_head");
    send_flit(mk(BODY_FLIT, 32'hA1), w, 2, "stray_body");
    send_flit('0, w, 2, "stray_idle");
    send_flit(mk(TAIL_FLIT, 32'hA2), w, -1, "stray_tail");

    // Framing error: first flit is BODY, still forwarded.
    arbitrate(4'b1000, "frame", w);
    send_packet(w, 3, 0, 0, 1, "frame");

    // Randomized traffic.
    for (int p = 0; p < 40; p++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      bus.i_req = mask;
      bus.i_out_rdy = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        tick();
        check("rand_bp_no_grant", 64'(bus.o_grant), 64'(0));
      end
      arbitrate(mask, "rand", w);
      bus.i_req = N'($urandom);
      send_packet(w, $urandom_range(1, 5), 25, 10, 0, "rand");
    end

    // Asynchronous reset mid-packet.
    arbitrate(4'b1111, "rst", w);
    send_flit(mk(HEAD_FLIT, 32'hC0), w, -1, "rst_head");
    send_flit(mk(BODY_FLIT, 32'hC1), w, -1, "rst_body");
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    bus.i_flit = '0;
    bus.i_req = '0;
    tick();
    check_all_zero("rst_hold");
    reset_n = 1'b1;
    ptr_m = 0;
    cnt_m = 0;
    err_m = '0;
    locked_m = 0;
    arbitrate(4'b1111, "post_rst", w);
    check("post_rst_owner0", 64'(o_owner), 64'(0));
    send_packet(w, 2, 0, 0, 0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
